// File: rtl/por_reset_seq_pkg.sv
// Shared types for the power-on reset sequencer: FSM state encoding and parameter helpers.
package por_reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_PG  = 3'd0,
        DEBOUNCE = 3'd1,
        HOLD     = 3'd2,
        RUN      = 3'd3,
        FAULT    = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/por_reset_seq_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on async reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/por_reset_seq.sv
// Power-on reset sequencer: synchronises and debounces pwr_good, then holds rst_out for HOLD_CYCLES.
// Optional PG_TIMEOUT_EN adds a sticky fault when the sequence fails to reach RUN in time.
module por_reset_seq
    import por_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 16,
    parameter int HOLD_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic clk_in,
    input  logic rst,
    input  logic pwr_good,
    output logic rst_out,
    output logic ready,
    output logic fault
);

    localparam int MAX_SPAN = max3(DEB_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("por_reset_seq: SYNC_STAGES must be >= 2 and all cycle counts >= 1");
    end

    if ($clog2(MAX_SPAN) > CNT_W) begin : g_bad_cnt_w
        $error("por_reset_seq: CNT_W too narrow for the largest terminal count");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             pg_s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_pg_sync (
        .clk   (clk_in),
        .rst_n (rst),
        .d     (pwr_good),
        .q     (pg_s)
    );

`ifdef PG_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_next;
    logic             tmo_hit;

    // Frozen in FAULT so the counter can never wrap while the block is parked there.
    always_comb begin
        tmo_hit  = (state != RUN) && (state != FAULT) && (tmo_cnt == TMO_LAST);
        tmo_next = tmo_cnt;
        if (state == RUN) begin
            tmo_next = '0;
        end else if (state != FAULT) begin
            tmo_next = tmo_cnt + CNT_W'(1);
        end
    end
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            WAIT_PG: begin
                if (pg_s) begin
                    next_state = DEBOUNCE;
                    cnt_next   = '0;
                end
            end
            DEBOUNCE: begin
                if (!pg_s) begin
                    next_state = WAIT_PG;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    next_state = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!pg_s) begin
                    next_state = WAIT_PG;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    next_state = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!pg_s) begin
                    next_state = WAIT_PG;
                    cnt_next   = '0;
                end
            end
`ifdef PG_TIMEOUT_EN
            FAULT: begin
                next_state = FAULT;
                cnt_next   = '0;
            end
`endif
            default: begin
                next_state = WAIT_PG;
                cnt_next   = '0;
            end
        endcase
`ifdef PG_TIMEOUT_EN
        // A timeout outranks any normal progress made on the same edge.
        if (tmo_hit) begin
            next_state = FAULT;
            cnt_next   = '0;
        end
`endif
    end

    // Outputs are registered from next_state so they change on the same edge as the state.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state   <= WAIT_PG;
            cnt     <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
`ifdef PG_TIMEOUT_EN
            tmo_cnt <= '0;
            fault   <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            rst_out <= (next_state != RUN);
            ready   <= (next_state == RUN);
`ifdef PG_TIMEOUT_EN
            tmo_cnt <= tmo_next;
            fault   <= (next_state == FAULT);
`endif
        end
    end

`ifndef PG_TIMEOUT_EN
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_por_reset_seq.sv
// Directed bench for por_reset_seq with SYNC_STAGES=2, DEB_CYCLES=4, HOLD_CYCLES=10, TIMEOUT_CYCLES=40.
module tb_por_reset_seq;

    localparam int SYNC_STAGES    = 2;
    localparam int DEB_CYCLES     = 4;
    localparam int HOLD_CYCLES    = 10;
    localparam int TIMEOUT_CYCLES = 40;
    localparam int CNT_W          = 16;

    // Edges from the first edge that samples pwr_good=1 up to and including the rst_out fall.
    localparam int FULL_EDGES = 1 + SYNC_STAGES + DEB_CYCLES + HOLD_CYCLES;   // 17
    // Edges from the edge that returned to WAIT_PG (pg_s already high) to the fall.
    localparam int FSM_EDGES  = 1 + DEB_CYCLES + HOLD_CYCLES;                 // 15

    logic clk_in   = 1'b0;
    logic rst      = 1'b0;
    logic pwr_good = 1'b0;
    logic rst_out;
    logic ready;
    logic fault;

    int checks = 0;
    int errors = 0;

    por_reset_seq #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEB_CYCLES     (DEB_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .pwr_good (pwr_good),
        .rst_out  (rst_out),
        .ready    (ready),
        .fault    (fault)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Counts edges until rst_out drops; returns 0 if it never does within the limit.
    task automatic edges_to_release(input int limit, output int n);
        int k;
        k = 0;
        n = 0;
        while (k < limit && n == 0) begin
            tick();
            k++;
            if (rst_out === 1'b0) n = k;
        end
    endtask

    // Leaves rst released just after an edge, so the next edge is the first one sampling pwr_good.
    task automatic reset_pulse(input logic pg);
        rst      = 1'b0;
        pwr_good = pg;
        tick(2);
        rst = 1'b1;
    endtask

    int n;

    initial begin
        // Test 1: reset held with pwr_good high, then full release latency.
        rst      = 1'b0;
        pwr_good = 1'b1;
        tick(4);
        check("t1_rst_out_in_reset", 32'(rst_out), 1);
        check("t1_ready_in_reset",   32'(ready),   0);
        check("t1_fault_in_reset",   32'(fault),   0);
        rst = 1'b1;
        edges_to_release(60, n);
        check("t1_latency", n, FULL_EDGES);
        check("t1_ready_run", 32'(ready), 1);
        check("t1_fault_run", 32'(fault), 0);

        // Test 3: one-cycle power-good dip while in RUN.
        pwr_good = 1'b0;
        tick();
        pwr_good = 1'b1;
        tick();
        check("t3_run_edge2", 32'(rst_out), 0);
        tick();
        check("t3_rst_out_edge3", 32'(rst_out), 1);
        check("t3_ready_edge3",   32'(ready),   0);
        edges_to_release(60, n);
        check("t3_relatch", n, FSM_EDGES);
        check("t3_ready_again", 32'(ready), 1);

        // Test 4a: async reset in RUN takes effect before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("t4_async_rst_out", 32'(rst_out), 1);
        check("t4_async_ready",   32'(ready),   0);
        tick(2);
        rst      = 1'b1;
        pwr_good = 1'b1;

        // Test 4b: async reset during HOLD at cnt=5 discards the partial count.
        tick(12);
        check("t4_state_hold", 32'(dut.state), 2);
        check("t4_cnt_5",      32'(dut.cnt),   5);
        #2 rst = 1'b0;
        #1;
        check("t4_state_cleared", 32'(dut.state), 0);
        check("t4_cnt_cleared",   32'(dut.cnt),   0);
        check("t4_rst_out_hold",  32'(rst_out),   1);
        tick(2);
        rst = 1'b1;
        edges_to_release(60, n);
        check("t4_restart_latency", n, FULL_EDGES);

        // Test 2: 3-cycle glitch shorter than debounce never releases reset.
        reset_pulse(1'b0);
        pwr_good = 1'b1;
        tick(3);
        pwr_good = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_glitch_rst_out", 32'(rst_out), 1);
        end
        check("t2_state_wait_pg", 32'(dut.state), 0);
        check("t2_ready_low",     32'(ready),     0);
        pwr_good = 1'b1;
        edges_to_release(60, n);
        check("t2_full_latency", n, FULL_EDGES);

`ifdef PG_TIMEOUT_EN
        // Test 5: power-good absent long enough to time out; fault is sticky until reset.
        reset_pulse(1'b0);
        tick(TIMEOUT_CYCLES - 1);
        check("t5_fault_before", 32'(fault), 0);
        tick();
        check("t5_fault_at_edge", 32'(fault),   1);
        check("t5_rst_out_fault", 32'(rst_out), 1);
        check("t5_ready_fault",   32'(ready),   0);
        pwr_good = 1'b1;
        tick(30);
        check("t5_fault_sticky",   32'(fault),   1);
        check("t5_rst_out_sticky", 32'(rst_out), 1);
        rst = 1'b0;
        #1;
        check("t5_fault_cleared", 32'(fault), 0);
        tick(2);
        rst = 1'b1;
        edges_to_release(60, n);
        check("t5_recover_latency", n, FULL_EDGES);
`else
        // Test 6: long power-good absence never faults, then releases normally.
        reset_pulse(1'b0);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i % 100 == 99) begin
                check("t6_fault_low",     32'(fault),   0);
                check("t6_rst_out_held",  32'(rst_out), 1);
            end
        end
        pwr_good = 1'b1;
        edges_to_release(60, n);
        check("t6_latency", n, FULL_EDGES);
        check("t6_fault_run", 32'(fault), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
